// File: rtl/ram_mar.sv
// Memory stage behind the microcode decoder: MAR, 16x8 program/data RAM and a
// ready/valid byte loader that fills RAM from address 0 while prog_mode is high.
module ram_mar #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_mode,
    input  logic              mi,
    input  logic              ri,
    input  logic              ro,
    input  logic [DATA_W-1:0] bus_in,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    input  logic [DATA_W-1:0] prog_data,
    input  logic              prog_valid,
    output logic              prog_ready,
    output logic              prog_done,
    output logic [ADDR_W-1:0] load_addr,
    output logic [ADDR_W-1:0] mar
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] mar_q;
    logic [ADDR_W-1:0] load_addr_q;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              run_s;
    logic              xfer_s;
    logic              we_s;
    logic [ADDR_W-1:0] waddr_s;
    logic [DATA_W-1:0] wdata_s;

    // Single RAM write port shared by the loader and the decoder; the modes are exclusive.
    always_comb begin
        run_s  = (state_q == IDLE) && !prog_mode;
        xfer_s = (state_q == LOAD) && prog_mode && prog_valid;
        we_s   = xfer_s || (run_s && ri);
        if (xfer_s) begin
            waddr_s = load_addr_q;
            wdata_s = prog_data;
        end else begin
            waddr_s = mar_q;
            wdata_s = bus_in;
        end
    end

    // Loader FSM together with MAR and load address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            mar_q       <= '0;
            load_addr_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (prog_mode) begin
                        state_q     <= LOAD;
                        load_addr_q <= '0;
                    end else if (mi) begin
                        mar_q <= bus_in[ADDR_W-1:0];
                    end
                end
                LOAD: begin
                    if (!prog_mode) begin
                        state_q <= IDLE;
                        mar_q   <= '0;
                    end else if (prog_valid) begin
                        load_addr_q <= load_addr_q + ADDR_W'(1);
                        if (load_addr_q == {ADDR_W{1'b1}}) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (!prog_mode) begin
                        state_q <= IDLE;
                        mar_q   <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    mar_q   <= '0;
                end
            endcase
        end
    end

    // RAM array; reset clears every word so a reset mid-load leaves no stale program.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_s) begin
            mem_q[waddr_s] <= wdata_s;
        end
    end

    assign bus_out    = mem_q[mar_q];
    assign bus_oe     = ro && !prog_mode;
    assign prog_ready = (state_q == LOAD) && prog_mode;
    assign prog_done  = (state_q == DONE);
    assign load_addr  = load_addr_q;
    assign mar        = mar_q;

endmodule

// File: tb/tb_ram_mar.sv
// Self-checking bench for ram_mar: directed scenarios plus randomized traffic
// compared against a behavioural model of MAR, RAM and loader progress.
module tb_ram_mar;

    logic       clk        = 1'b0;
    logic       rst        = 1'b0;
    logic       prog_mode  = 1'b0;
    logic       mi         = 1'b0;
    logic       ri         = 1'b0;
    logic       ro         = 1'b0;
    logic       prog_valid = 1'b0;
    logic [7:0] bus_in     = 8'h00;
    logic [7:0] prog_data  = 8'h00;
    logic [7:0] bus_out;
    logic       bus_oe;
    logic       prog_ready;
    logic       prog_done;
    logic [3:0] load_addr;
    logic [3:0] mar;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: RAM contents, MAR, loader address and loader phase.
    logic [7:0] m_mem [16];
    logic [3:0] m_mar;
    logic [3:0] m_laddr;
    bit         m_loading;
    bit         m_done;

    ram_mar #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .prog_mode  (prog_mode),
        .mi         (mi),
        .ri         (ri),
        .ro         (ro),
        .bus_in     (bus_in),
        .bus_out    (bus_out),
        .bus_oe     (bus_oe),
        .prog_data  (prog_data),
        .prog_valid (prog_valid),
        .prog_ready (prog_ready),
        .prog_done  (prog_done),
        .load_addr  (load_addr),
        .mar        (mar)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
        m_mar     = 4'd0;
        m_laddr   = 4'd0;
        m_loading = 1'b0;
        m_done    = 1'b0;
    endtask

    // Apply one clock edge's worth of the spec rules to the model.
    task automatic model_edge();
        if (!prog_mode) begin
            if (m_loading || m_done) begin
                m_loading = 1'b0;
                m_done    = 1'b0;
                m_mar     = 4'd0;
            end else begin
                if (ri) m_mem[m_mar] = bus_in;
                if (mi) m_mar = bus_in[3:0];
            end
        end else if (!m_loading && !m_done) begin
            m_loading = 1'b1;
            m_laddr   = 4'd0;
        end else if (m_loading && prog_valid) begin
            m_mem[m_laddr] = prog_data;
            if (m_laddr == 4'd15) begin
                m_loading = 1'b0;
                m_done    = 1'b1;
            end
            m_laddr = m_laddr + 4'd1;
        end
    endtask

    task automatic check_outputs();
        check_eq("bus_out",    32'(bus_out),    32'(m_mem[m_mar]));
        check_eq("bus_oe",     32'(bus_oe),     32'(ro && !prog_mode));
        check_eq("prog_ready", 32'(prog_ready), 32'(m_loading && prog_mode));
        check_eq("prog_done",  32'(prog_done),  32'(m_done));
        check_eq("load_addr",  32'(load_addr),  32'(m_laddr));
        check_eq("mar",        32'(mar),        32'(m_mar));
    endtask

    // Called at a negedge with inputs set: check, clock once, return at next negedge.
    task automatic cycle();
        #1;
        check_outputs();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic clear_strobes();
        mi = 1'b0; ri = 1'b0; ro = 1'b0; prog_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Read every RAM word in run mode through mi/ro and compare with the model.
    task automatic sweep();
        prog_mode = 1'b0;
        clear_strobes();
        for (int a = 0; a < 16; a++) begin
            mi = 1'b1; ro = 1'b0; bus_in = 8'(a) | 8'hA0;
            cycle();
            mi = 1'b0; ro = 1'b1;
            cycle();
        end
        clear_strobes();
    endtask

    initial begin
        int cnt;
        int ready_cnt;
        model_reset();
        @(negedge clk);
        do_reset();

        // Back-to-back load of 0x10..0x1F, then run-mode read of address 5.
        prog_mode = 1'b1;
        cycle();
        ready_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            prog_valid = 1'b1; prog_data = 8'h10 + 8'(i);
            #1;
            if (prog_ready) ready_cnt++;
            cycle();
        end
        prog_valid = 1'b0;
        #1;
        check_eq("t1_ready_cycles", 32'(ready_cnt), 32'd16);
        check_eq("t1_done", 32'(prog_done), 32'd1);
        check_eq("t1_ready_low", 32'(prog_ready), 32'd0);
        cycle();
        prog_mode = 1'b0;
        cycle();
        mi = 1'b1; bus_in = 8'h05;
        cycle();
        mi = 1'b0; ro = 1'b1;
        #1;
        check_eq("t1_bus_out", 32'(bus_out), 32'h15);
        check_eq("t1_bus_oe", 32'(bus_oe), 32'd1);
        cycle();
        clear_strobes();

        // Loader with prog_valid every other cycle.
        prog_mode = 1'b1;
        cycle();
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (prog_done) break;
            prog_valid = k[0];
            prog_data  = 8'($urandom);
            cycle();
            cnt++;
        end
        prog_valid = 1'b0;
        #1;
        check_eq("t2_cycles_to_done", 32'(cnt), 32'd32);
        check_eq("t2_load_addr", 32'(load_addr), 32'd0);
        sweep();

        // Run-mode MAR/RAM access.
        mi = 1'b1; bus_in = 8'hF3;
        cycle();
        mi = 1'b0;
        #1;
        check_eq("t3_mar", 32'(mar), 32'd3);
        ri = 1'b1; bus_in = 8'hAA;
        cycle();
        ri = 1'b0; ro = 1'b1;
        #1;
        check_eq("t3_read", 32'(bus_out), 32'hAA);
        mi = 1'b1; ri = 1'b1; bus_in = 8'h07;
        #1;
        check_eq("t3_prewrite", 32'(bus_out), 32'hAA);
        cycle();
        mi = 1'b0; ri = 1'b0;
        #1;
        check_eq("t3_mar7", 32'(mar), 32'd7);
        mi = 1'b1; bus_in = 8'h03;
        cycle();
        mi = 1'b0;
        #1;
        check_eq("t3_ram3", 32'(bus_out), 32'h07);
        cycle();
        clear_strobes();

        // Aborted load keeps written words and restarts at address 0.
        do_reset();
        prog_mode = 1'b1;
        cycle();
        for (int i = 0; i < 5; i++) begin
            prog_valid = 1'b1; prog_data = 8'(i + 1);
            cycle();
        end
        prog_mode = 1'b0; prog_data = 8'hEE;
        cycle();
        prog_valid = 1'b0;
        #1;
        check_eq("t4_done", 32'(prog_done), 32'd0);
        check_eq("t4_mar", 32'(mar), 32'd0);
        check_eq("t4_load_addr", 32'(load_addr), 32'd5);
        check_eq("t4_ready", 32'(prog_ready), 32'd0);
        for (int a = 0; a < 16; a++) begin
            mi = 1'b1; bus_in = 8'(a);
            cycle();
            mi = 1'b0;
            #1;
            check_eq("t4_ram", 32'(bus_out), (a < 5) ? 32'(a + 1) : 32'd0);
        end
        prog_mode = 1'b1;
        cycle();
        #1;
        check_eq("t4_restart_addr", 32'(load_addr), 32'd0);
        prog_valid = 1'b1; prog_data = 8'h99;
        cycle();
        prog_valid = 1'b0; prog_mode = 1'b0;
        cycle();
        ro = 1'b1;
        #1;
        check_eq("t4_restart_word", 32'(bus_out), 32'h99);
        cycle();
        clear_strobes();

        // Decoder strobes ignored in prog_mode; async reset mid-load.
        prog_mode = 1'b1;
        cycle();
        prog_valid = 1'b1; prog_data = 8'h5A;
        cycle();
        prog_valid = 1'b0;
        mi = 1'b1; ri = 1'b1; ro = 1'b1; bus_in = 8'h3C;
        #1;
        check_eq("t5_oe", 32'(bus_oe), 32'd0);
        cycle();
        cycle();
        clear_strobes();
        #1;
        check_eq("t5_mar", 32'(mar), 32'd0);
        #1;
        rst = 1'b0;
        model_reset();
        #1;
        check_eq("t5_rst_ready", 32'(prog_ready), 32'd0);
        check_eq("t5_rst_load_addr", 32'(load_addr), 32'd0);
        check_eq("t5_rst_bus_out", 32'(bus_out), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        sweep();

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 23) == 0) prog_mode = ~prog_mode;
            mi         = ($urandom_range(0, 3) == 0);
            ri         = ($urandom_range(0, 2) == 0);
            ro         = ($urandom_range(0, 1) == 0);
            prog_valid = ($urandom_range(0, 2) != 0);
            bus_in     = 8'($urandom);
            prog_data  = 8'($urandom);
            cycle();
        end
        sweep();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_mar.md
Name: ram_mar

Overview:
- Memory stage directly downstream of the microcode decoder.
- Holds the memory address register (MAR) and the 16x8 program/data RAM, consuming the decoder's mi, ri and ro strobes.
- Provides a ready/valid byte-stream loader that fills RAM from address 0 while prog_mode is high, so programs are loaded before the decoder runs.
- Datapath registers update on posedge clk; the decoder drives its strobes on negedge, so they are stable at posedge.

Parameters:
ADDR_W, 4, MAR and loader address width; RAM depth is 2**ADDR_W
DATA_W, 8, bus and RAM word width

Ports:
clk  in  1  system clock; all state updates on posedge
rst  in  1  asynchronous active-low reset
prog_mode  in  1  1 = program-load mode, 0 = run mode
mi  in  1  decoder strobe: load MAR from bus_in[ADDR_W-1:0]
ri  in  1  decoder strobe: write bus_in to RAM[MAR]
ro  in  1  decoder strobe: drive RAM[MAR] onto bus
bus_in  in  DATA_W  current shared bus value
bus_out  out  DATA_W  RAM[MAR], combinational read
bus_oe  out  1  bus_out is valid for the bus mux
prog_data  in  DATA_W  loader byte
prog_valid  in  1  loader byte valid
prog_ready  out  1  loader can accept a byte this cycle
prog_done  out  1  all 2**ADDR_W words loaded
load_addr  out  ADDR_W  next loader write address, for display
mar  out  ADDR_W  current MAR value

Behaviour:
Reset (rst=0, asynchronous):
- mar=0, RAM words all cleared to 0, state=IDLE, load_addr=0.
- prog_ready=0, prog_done=0, bus_oe=0.
- bus_out = RAM[0] = 0.

Run mode (prog_mode=0, state IDLE):
- mi=1 at posedge: mar <= bus_in[ADDR_W-1:0]; upper bus bits ignored.
- ri=1 at posedge: RAM[mar] <= bus_in, using the MAR value before this edge.
- mi and ri together: the write goes to the old mar, and mar updates on the same edge.
- bus_out = RAM[mar] combinationally at all times.
- bus_oe = ro & ~prog_mode. Zero-cycle read latency: the value is valid the same cycle ro is asserted.
- ro with ri together: bus_out shows the pre-write data. A write is visible on bus_out one cycle later.

Loader FSM (states IDLE, LOAD, DONE; evaluated at posedge):
- IDLE -> LOAD when prog_mode=1; load_addr <= 0.
- LOAD:
  - prog_ready=1.
  - When prog_valid & prog_ready: RAM[load_addr] <= prog_data and load_addr <= load_addr+1.
  - If load_addr == 2**ADDR_W-1 on that transfer: go to DONE; load_addr wraps to 0.
  - prog_valid=0: hold.
- DONE:
  - prog_ready=0, prog_done=1.
  - prog_valid is ignored and RAM is unchanged.
- Any state with prog_mode=0 -> IDLE at the next posedge.
  - prog_done and prog_ready clear.
  - mar <= 0, so execution restarts with a clean MAR.
  - load_addr holds its value.
- prog_mode dropping mid-LOAD aborts the load. Words already written are kept; words not yet written keep their previous contents.
- No transfer occurs on the edge at which prog_mode is sampled 0, even if prog_valid=1.
- While prog_mode=1: mi, ri and ro are ignored (no MAR or RAM update from the bus) and bus_oe=0.
- prog_ready is a registered-state function (state==LOAD && prog_mode). It does not depend combinationally on prog_valid.
- Reset asserted mid-load: immediate return to reset values, including cleared RAM.
- There is exactly one RAM write port. A loader write and a run-mode write can never coincide because the modes are exclusive.

Test Plan:
1. Reset, then prog_mode=1 and stream 16 bytes 0x10..0x1F back-to-back with prog_valid=1 -> prog_ready high for 16 cycles, then prog_done=1 and prog_ready=0; prog_mode=0, then mi with bus_in=0x05 and ro -> bus_out=0x15, bus_oe=1.
2. Loader with prog_valid toggling every other cycle, 16 bytes -> prog_done after exactly 32 cycles; RAM[k]=k-th byte; load_addr=0 at done.
3. Run mode: mi with bus_in=0xF3 -> mar=3; next cycle ri with bus_in=0xAA -> RAM[3]=0xAA; ro -> bus_out=0xAA. Then mi+ri together with bus_in=0x07 -> RAM[3]=0x07 and mar=7.
4. Abort: load 5 bytes (0x01..0x05), drop prog_mode -> state IDLE, prog_done=0, mar=0, load_addr=5; RAM[0..4]=0x01..0x05 and RAM[5..15]=0. Re-enter prog_mode -> load restarts at address 0.
5. In prog_mode assert mi/ri/ro with bus_in=0x3C -> mar and RAM unchanged, bus_oe=0. Assert rst asynchronously mid-LOAD (between clock edges) -> all outputs and RAM return to 0 immediately.
